// File: rtl/updown_counter_pkg.sv
// Shared constants and types for the up/down counter slice.
// Used by updown_counter_n and inc_dec_n.
package updown_counter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned WIDTH_MIN     = 2;
  localparam int unsigned WIDTH_MAX     = 32;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD
  } op_e;

  // Non-reset priority: load beats a count step, which beats hold.
  function automatic op_e decode_op(input logic load, input logic en);
    if (load)    return OP_LOAD;
    else if (en) return OP_STEP;
    else         return OP_HOLD;
  endfunction

endpackage

// File: rtl/inc_dec_n.sv
// Ripple incrementer/decrementer: per-bit half-adder (up) or half-subtractor (down)
// cells chained LSB to MSB; co is the carry/borrow out of the MSB.
module inc_dec_n
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic             up,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  always_comb begin : ripple
    logic chain;
    chain = 1'b1;
    y     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      y[i] = a[i] ^ chain;
      // Carry propagates through a 1 when counting up, borrow through a 0 when down.
      chain = chain & ((up == DIR_UP) ? a[i] : ~a[i]);
    end
    co = chain;
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parameterised up/down counter with parallel load, carry/borrow pulse and zero flag.
// Define UPDOWN_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module updown_counter_n
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             zero
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("updown_counter_n: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  if ((64'(INIT) >> WIDTH) != 64'd0) begin : g_bad_init
    $error("updown_counter_n: INIT=%0d does not fit in %0d bits", INIT, WIDTH);
  end

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             zero_q,  zero_d;
  logic [WIDTH-1:0] step_val;
  logic             step_co;
  op_e              op;

  inc_dec_n #(
    .WIDTH(WIDTH)
  ) u_inc_dec (
    .a (count_q),
    .up(up),
    .y (step_val),
    .co(step_co)
  );

  always_comb begin
    op      = decode_op(load, en);
    count_d = count_q;
    carry_d = 1'b0;
    case (op)
      OP_LOAD: count_d = load_val;
      OP_STEP: begin
        carry_d = step_co;
`ifdef UPDOWN_COUNTER_SAT_EN
        count_d = step_co ? count_q : step_val;
`else
        count_d = step_val;
`endif
      end
      default: count_d = count_q;
    endcase
    // Zero is derived from the next value so it registers alongside count.
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= INIT_V;
      carry_q <= 1'b0;
      zero_q  <= (INIT_V == '0);
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n: four instances (W4, W8, W3/INIT5, W32/INIT all-ones),
// directed vectors followed by a randomised run against a behavioural model.
module tb_updown_counter_n;

`ifdef UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i [4];
  logic        load_i[4];
  logic        en_i  [4];
  logic        up_i  [4];
  logic [31:0] lv_i  [4];

  logic [3:0]  cnt_a;
  logic [7:0]  cnt_b;
  logic [2:0]  cnt_c;
  logic [31:0] cnt_d;
  logic        cy_o [4];
  logic        zr_o [4];
  logic [31:0] cnt_o[4];

  always_comb begin
    cnt_o[0] = 32'(cnt_a);
    cnt_o[1] = 32'(cnt_b);
    cnt_o[2] = 32'(cnt_c);
    cnt_o[3] = cnt_d;
  end

  updown_counter_n #(.WIDTH(4), .INIT(0)) u_w4 (
    .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .up(up_i[0]), .load(load_i[0]),
    .load_val(lv_i[0][3:0]), .count(cnt_a), .carry(cy_o[0]), .zero(zr_o[0]));

  updown_counter_n #(.WIDTH(8), .INIT(0)) u_w8 (
    .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .up(up_i[1]), .load(load_i[1]),
    .load_val(lv_i[1][7:0]), .count(cnt_b), .carry(cy_o[1]), .zero(zr_o[1]));

  updown_counter_n #(.WIDTH(3), .INIT(5)) u_w3 (
    .clk(clk), .rst(rst_i[2]), .en(en_i[2]), .up(up_i[2]), .load(load_i[2]),
    .load_val(lv_i[2][2:0]), .count(cnt_c), .carry(cy_o[2]), .zero(zr_o[2]));

  updown_counter_n #(.WIDTH(32), .INIT(32'hFFFF_FFFF)) u_w32 (
    .clk(clk), .rst(rst_i[3]), .en(en_i[3]), .up(up_i[3]), .load(load_i[3]),
    .load_val(lv_i[3]), .count(cnt_d), .carry(cy_o[3]), .zero(zr_o[3]));

  typedef struct {
    logic [31:0] count;
    logic        carry;
    logic        zero;
    string       tag;
  } exp_t;

  exp_t sb[4][$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic int unsigned wof(input int d);
    case (d)
      0:       return 4;
      1:       return 8;
      2:       return 3;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] maskof(input int d);
    if (wof(d) == 32) return 32'hFFFF_FFFF;
    return (32'd1 << wof(d)) - 32'd1;
  endfunction

  function automatic logic [31:0] initof(input int d);
    case (d)
      2:       return 32'd5;
      3:       return 32'hFFFF_FFFF;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 4; d++) begin
      rst_i[d]  = 1'b0;
      load_i[d] = 1'b0;
      en_i[d]   = 1'b0;
      up_i[d]   = 1'b0;
      lv_i[d]   = '0;
    end
  endtask

  task automatic push(input int d, input logic [31:0] c, input logic cy, input logic z,
                      input string tag);
    exp_t e;
    e.count = c;
    e.carry = cy;
    e.zero  = z;
    e.tag   = tag;
    sb[d].push_back(e);
  endtask

  // One directed cycle on a single instance; all others idle and hold.
  task automatic drv(input int d, input logic r, input logic l, input logic e, input logic u,
                     input logic [31:0] lv, input logic [31:0] ec, input logic ecy,
                     input logic ez, input string tag);
    @(negedge clk);
    idle_all();
    rst_i[d]  = r;
    load_i[d] = l;
    en_i[d]   = e;
    up_i[d]   = u;
    lv_i[d]   = lv;
    push(d, ec, ecy, ez, tag);
  endtask

  // Monitor: every instance presents a result one edge after each pushed stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (sb[d].size() != 0) begin
          e = sb[d].pop_front();
          vectors++;
          if (cnt_o[d] !== e.count) begin
            $display("FAIL %s dut%0d count: got %h want %h", e.tag, d, cnt_o[d], e.count);
            miscompares++;
          end
          if (cy_o[d] !== e.carry) begin
            $display("FAIL %s dut%0d carry: got %b want %b", e.tag, d, cy_o[d], e.carry);
            miscompares++;
          end
          if (zr_o[d] !== e.zero) begin
            $display("FAIL %s dut%0d zero: got %b want %b", e.tag, d, zr_o[d], e.zero);
            miscompares++;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] mcnt[4];

  initial begin
    idle_all();

    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      rst_i[d] = 1'b1;
      push(d, initof(d), 1'b0, initof(d) == 32'd0, "reset");
    end

`ifndef UPDOWN_COUNTER_SAT_EN
    // W4: 17 up steps from 0 wrap once; then turn around with back-to-back wraps.
    for (int i = 1; i <= 17; i++)
      drv(0, 0, 0, 1, 1, 0, 32'(i % 16), i == 16, i == 16, "w4_up");
    drv(0, 0, 0, 1, 0, 0, 32'd0,  1'b0, 1'b1, "w4_turn_dn");
    drv(0, 0, 0, 1, 0, 0, 32'd15, 1'b1, 1'b0, "w4_borrow");
    drv(0, 0, 0, 1, 1, 0, 32'd0,  1'b1, 1'b1, "w4_turn_up_wrap");
    drv(0, 0, 0, 0, 1, 0, 32'd0,  1'b0, 1'b1, "w4_hold");

    // W8: load 3, count down through zero.
    drv(1, 0, 1, 0, 0, 32'h03, 32'h03, 1'b0, 1'b0, "w8_load3");
    drv(1, 0, 0, 1, 0, 0,      32'h02, 1'b0, 1'b0, "w8_dn1");
    drv(1, 0, 0, 1, 0, 0,      32'h01, 1'b0, 1'b0, "w8_dn2");
    drv(1, 0, 0, 1, 0, 0,      32'h00, 1'b0, 1'b1, "w8_dn3");
    drv(1, 0, 0, 1, 0, 0,      32'hFF, 1'b1, 1'b0, "w8_dn_borrow");
    drv(1, 0, 1, 1, 1, 32'h5A, 32'h5A, 1'b0, 1'b0, "w8_load_over_en");
    drv(1, 0, 1, 0, 0, 32'hFF, 32'hFF, 1'b0, 1'b0, "w8_load_ff");
    drv(1, 0, 0, 1, 1, 0,      32'h00, 1'b1, 1'b1, "w8_up_wrap");
    drv(1, 0, 1, 1, 1, 32'h80, 32'h80, 1'b0, 1'b0, "w8_load_clears_carry");
    drv(1, 0, 1, 0, 0, 32'hFF, 32'hFF, 1'b0, 1'b0, "w8_load_ff2");
    drv(1, 1, 1, 1, 1, 32'h33, 32'h00, 1'b0, 1'b1, "w8_rst_over_all");
    drv(1, 0, 0, 1, 1, 0,      32'h01, 1'b0, 1'b0, "w8_after_rst");
    drv(1, 0, 0, 0, 1, 0,      32'h01, 1'b0, 1'b0, "w8_hold");

    // W3 with INIT=5.
    drv(2, 0, 0, 1, 0, 0, 32'd4, 1'b0, 1'b0, "w3_dn");
    drv(2, 0, 1, 1, 0, 0, 32'd0, 1'b0, 1'b1, "w3_load0");
    drv(2, 0, 0, 1, 0, 0, 32'd7, 1'b1, 1'b0, "w3_borrow");
    drv(2, 0, 0, 0, 0, 0, 32'd7, 1'b0, 1'b0, "w3_hold");
    drv(2, 1, 0, 1, 1, 0, 32'd5, 1'b0, 1'b0, "w3_rst_init");

    // W32 with INIT all-ones.
    drv(3, 0, 0, 1, 1, 0, 32'h0000_0000, 1'b1, 1'b1, "w32_wrap");
    drv(3, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, "w32_borrow");
    drv(3, 0, 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "w32_load");
    drv(3, 0, 0, 1, 0, 0, 32'h7FFF_FFFF, 1'b0, 1'b0, "w32_dn_msb");
`else
    drv(0, 0, 1, 0, 0, 32'hF, 32'hF, 1'b0, 1'b0, "w4_load_f");
    for (int i = 0; i < 3; i++)
      drv(0, 0, 0, 1, 1, 0, 32'hF, 1'b1, 1'b0, "w4_sat_hi");
    drv(0, 0, 0, 1, 0, 0, 32'hE, 1'b0, 1'b0, "w4_dn_from_max");
    drv(0, 0, 1, 0, 0, 0, 32'h0, 1'b0, 1'b1, "w4_load0");
    for (int i = 0; i < 2; i++)
      drv(0, 0, 0, 1, 0, 0, 32'h0, 1'b1, 1'b1, "w4_sat_lo");
    drv(0, 0, 0, 1, 1, 0, 32'h1, 1'b0, 1'b0, "w4_up_from_zero");

    drv(1, 0, 1, 0, 0, 32'h03, 32'h03, 1'b0, 1'b0, "w8_load3");
    drv(1, 0, 0, 1, 0, 0,      32'h02, 1'b0, 1'b0, "w8_dn1");
    drv(1, 0, 0, 1, 0, 0,      32'h01, 1'b0, 1'b0, "w8_dn2");
    drv(1, 0, 0, 1, 0, 0,      32'h00, 1'b0, 1'b1, "w8_dn3");
    drv(1, 0, 0, 1, 0, 0,      32'h00, 1'b1, 1'b1, "w8_sat_lo");
    drv(1, 0, 1, 1, 1, 32'h5A, 32'h5A, 1'b0, 1'b0, "w8_load_over_en");
    drv(1, 1, 1, 1, 1, 32'h33, 32'h00, 1'b0, 1'b1, "w8_rst_over_all");

    drv(3, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, "w32_sat_hi");
    drv(3, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, "w32_hold");
`endif

    // Randomised run on all four instances at once against a behavioural model.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        logic        r, l, e, u, cy;
        logic [31:0] lv, mx;
        mx = maskof(d);
        r  = (n == 0) || ($urandom_range(0, 63) == 0);
        l  = ($urandom_range(0, 7) == 0);
        e  = ($urandom_range(0, 3) != 0);
        u  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0:       lv = 32'd0;
          1:       lv = mx;
          2:       lv = mx - 32'd1;
          3:       lv = 32'd1;
          default: lv = $urandom;
        endcase
        cy = 1'b0;
        if (r) mcnt[d] = initof(d);
        else if (l) mcnt[d] = lv & mx;
        else if (e) begin
          if (u) begin
            if (mcnt[d] == mx) begin
              cy      = 1'b1;
              mcnt[d] = SAT ? mx : 32'd0;
            end else mcnt[d] = mcnt[d] + 32'd1;
          end else begin
            if (mcnt[d] == 32'd0) begin
              cy      = 1'b1;
              mcnt[d] = SAT ? 32'd0 : mx;
            end else mcnt[d] = mcnt[d] - 32'd1;
          end
        end
        rst_i[d]  = r;
        load_i[d] = l;
        en_i[d]   = e;
        up_i[d]   = u;
        lv_i[d]   = lv;
        push(d, mcnt[d], cy, mcnt[d] == 32'd0, "rand");
      end
    end

    @(negedge clk);
    idle_all();
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 4; d++) begin
      if (sb[d].size() != 0) begin
        $display("FAIL drain dut%0d: %0d results outstanding, want 0", d, sb[d].size());
        miscompares++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
